eth_dma_rd_ctrl: RTL

- AXI4 read-burst controller that fetches a frame of `len` bytes from system memory at an arbitrary byte address and writes it, word-aligned, into the Ethernet TX packet buffer.
- Drives the eth_burst_align byte-realignment stage: issues the AR burst, pushes each R beat into the aligner, flushes the aligner's stored bytes after the last beat, and writes the aligned words to the buffer.
- Sits between the memory-side AXI interconnect and the TX buffer write port.

---
 rtl/eth_dma_rd_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/eth_dma_rd_ctrl.sv
// AXI4 read-burst controller: fetches a byte-addressed frame, feeds it through the
// external burst aligner and writes the word-aligned result into the TX buffer.
module eth_dma_rd_ctrl #(
    parameter int AXI_ADDR_W = 32,
    parameter int BUF_ADDR_W = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AXI_ADDR_W-1:0] addr,
    input  logic [9:0]            len,
    input  logic [BUF_ADDR_W-1:0] buf_base,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           algn_data,
    output logic                  algn_transfer,
    output logic                  algn_remaining,
    output logic [1:0]            algn_offset,
    output logic [9:0]            algn_len,
    input  logic [31:0]           algn_data_out,
    input  logic [7:0]            algn_axi_len,
    input  logic                  algn_first_valid,
    output logic [AXI_ADDR_W-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  buf_we,
    output logic [BUF_ADDR_W-1:0] buf_waddr,
    output logic [31:0]           buf_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_DATA,
        S_FLUSH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state;
    logic [AXI_ADDR_W-1:2]   addr_r;
    logic [BUF_ADDR_W-1:0]   base_r;
    logic [8:0]              words_req;
    logic [8:0]              words_written;
    logic                    first_xfer;
    logic                    write_pend;
    logic                    xfer;
    logic                    produce;
    logic [9:0]              fill;

    assign xfer          = rvalid & rready;
    // With a non-zero offset the aligner has nothing complete to emit on the first beat.
    assign produce       = xfer & ~(first_xfer & ~algn_first_valid);
    assign fill          = {1'b0, words_written} + {9'd0, write_pend} + {9'd0, produce};

    assign algn_data     = rdata;
    assign algn_transfer = xfer;
    assign araddr        = {addr_r, 2'b00};
    assign arlen         = algn_axi_len;
    assign arsize        = 3'b010;
    assign arburst       = 2'b01;
    assign buf_we        = write_pend && (words_written < words_req);
    assign buf_waddr     = base_r + BUF_ADDR_W'(words_written);
    assign buf_wdata     = algn_data_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            addr_r         <= '0;
            base_r         <= '0;
            words_req      <= '0;
            words_written  <= '0;
            first_xfer     <= 1'b0;
            write_pend     <= 1'b0;
            algn_offset    <= '0;
            algn_len       <= '0;
            algn_remaining <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
        end else begin
            done           <= 1'b0;
            algn_remaining <= 1'b0;
            write_pend     <= produce | algn_remaining;
            if (buf_we)
                words_written <= words_written + 9'd1;
            if (xfer) begin
                first_xfer <= 1'b0;
                if (rresp != 2'b00)
                    error <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_r        <= addr[AXI_ADDR_W-1:2];
                        algn_offset   <= addr[1:0];
                        algn_len      <= len;
                        base_r        <= buf_base;
                        words_req     <= {1'b0, len[9:2]} + 9'(|len[1:0]);
                        words_written <= '0;
                        first_xfer    <= 1'b1;
                        error         <= 1'b0;
                        if (len == 10'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_AR;
                            busy    <= 1'b1;
                            arvalid <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer && rlast) begin
                        rready <= 1'b0;
                        // Flush only if the words already written or in flight fall short.
                        if (fill < {1'b0, words_req}) begin
                            algn_remaining <= 1'b1;
                            state          <= S_FLUSH;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_FLUSH: state <= S_WAIT;
                S_WAIT: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
